// File: rtl/reg_file_mp.sv
// Two-read / one-write register file with registered reads and a hardware
// clear sequence (INIT) after reset. Define RF_BYPASS_EN for write-first reads.
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic              re,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] RA,
    output logic [DATA_W-1:0] RB,
    output logic              rvalid,
    output logic              ready
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    // One extra index bit so DEPTH == 2**ADDR_W still has a distinct terminal value.
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_idx;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_run;
    logic              w_wr_en;
    logic              w_ra_ok;
    logic              w_rb_ok;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_INIT && r_idx == LAST_IDX) w_state_nxt = S_RUN;
    end

    always_comb begin
        w_run = (r_state == S_RUN);
        ready = w_run;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_idx <= '0;
        else if (!w_run) r_idx <= r_idx + 1'b1;
    end

    assign w_wr_en = w_run && RegWrite && ({1'b0, WriteRegister} < DEPTH_C);
    assign w_ra_ok = ({1'b0, ra} < DEPTH_C);
    assign w_rb_ok = ({1'b0, rb} < DEPTH_C);

    // Storage carries no reset; the INIT sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (!w_run)       r_mem[r_idx[ADDR_W-1:0]] <= '0;
        else if (w_wr_en) r_mem[WriteRegister]     <= WriteData;
    end

    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        if (w_ra_ok) w_rd_a = r_mem[ra];
        if (w_rb_ok) w_rd_b = r_mem[rb];
`ifdef RF_BYPASS_EN
        if (w_wr_en && WriteRegister == ra) w_rd_a = WriteData;
        if (w_wr_en && WriteRegister == rb) w_rd_b = WriteData;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RA     <= '0;
            RB     <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= w_run && re;
            if (w_run && re) begin
                RA <= w_rd_a;
                RB <= w_rd_b;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: DEPTH=32 and DEPTH=20 instances share stimulus.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  ra = '0, rb = '0, wa = '0;
    logic        re = 1'b0, we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] ra32, rb32, ra20, rb20;
    logic        rv32, rv20, rdy32, rdy20;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef RF_BYPASS_EN
    localparam logic [31:0] SAME_CYC_EXP = 32'hDEADBEEF;
`else
    localparam logic [31:0] SAME_CYC_EXP = 32'h0;
`endif

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(32), .DEPTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .re(re),
        .WriteRegister(wa), .RegWrite(we), .WriteData(wd),
        .RA(ra32), .RB(rb32), .rvalid(rv32), .ready(rdy32));

    reg_file_mp #(.DATA_W(32), .DEPTH(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .re(re),
        .WriteRegister(wa), .RegWrite(we), .WriteData(wd),
        .RA(ra20), .RB(rb20), .rvalid(rv20), .ready(rdy20));

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] era;
        logic [31:0] erb;
        logic        ev;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from reset release until each ready rises; stops the
    // write/read attempts after drop_at cycles.
    task automatic measure_ready(input string tag, input int drop_at);
        int c32 = 0, c20 = 0;
        logic saw_rv = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (rdy32 && c32 == 0) c32 = c;
            if (rdy20 && c20 == 0) c20 = c;
            if ((rv32 && !rdy32) || (rv20 && !rdy20)) saw_rv = 1'b1;
            if (c == drop_at) begin
                we = 1'b0;
                re = 1'b0;
            end
        end
        check({tag, " ready32 cycles"}, c32, 32);
        check({tag, " ready20 cycles"}, c20, 20);
        check({tag, " rvalid in INIT"}, {31'b0, saw_rv}, 32'h0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd2,  32'h4,        1'b0, 5'd0,  5'd0,  32'h0,        32'h0,   1'b0};
        vecs[1]  = '{1'b1, 5'd4,  32'h200,      1'b0, 5'd0,  5'd0,  32'h0,        32'h0,   1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  5'd4,  32'h4,        32'h200, 1'b1};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  5'd7,  32'h4,        32'h200, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  5'd4,  32'h200,      32'h200, 1'b1};
        vecs[5]  = '{1'b1, 5'd5,  32'h11,       1'b0, 5'd0,  5'd0,  32'h200,      32'h200, 1'b0};
        vecs[6]  = '{1'b1, 5'd5,  32'h22,       1'b0, 5'd0,  5'd0,  32'h200,      32'h200, 1'b0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd2,  32'h22,       32'h4,   1'b1};
        vecs[8]  = '{1'b0, 5'd2,  32'hFFFF,     1'b1, 5'd2,  5'd31, 32'h4,        32'h0,   1'b1};
        vecs[9]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 5'd3,  5'd3,  SAME_CYC_EXP, SAME_CYC_EXP, 1'b1};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd2,  32'hDEADBEEF, 32'h4,   1'b1};
        vecs[11] = '{1'b1, 5'd25, 32'h55,       1'b0, 5'd0,  5'd0,  32'hDEADBEEF, 32'h4,   1'b0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd25, 5'd19, 32'h55,       32'h0,   1'b1};

        // Async reset with no clock edge required.
        #1 rst_n = 1'b0;
        #1;
        check("reset RA",     ra32, 32'h0);
        check("reset RB",     rb32, 32'h0);
        check("reset rvalid", {31'b0, rv32}, 32'h0);
        check("reset ready",  {31'b0, rdy32}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        measure_ready("init", 0);

        for (int a = 0; a < 32; a++) begin
            re = 1'b1; ra = 5'(a); rb = 5'(31 - a);
            step();
            check($sformatf("clear RA[%0d]", a), ra32, 32'h0);
            check($sformatf("clear RB[%0d]", 31 - a), rb32, 32'h0);
            check($sformatf("clear rvalid[%0d]", a), {31'b0, rv32}, 32'h1);
        end

        for (int i = 0; i < 13; i++) begin
            we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            re = vecs[i].re; ra = vecs[i].ra; rb = vecs[i].rb;
            step();
            check($sformatf("vec%0d RA", i), ra32, vecs[i].era);
            check($sformatf("vec%0d RB", i), rb32, vecs[i].erb);
            check($sformatf("vec%0d rvalid", i), {31'b0, rv32}, {31'b0, vecs[i].ev});
            if (i == 12) begin
                check("d20 RA addr25", ra20, 32'h0);
                check("d20 RB addr19", rb20, 32'h0);
                check("d20 rvalid",    {31'b0, rv20}, 32'h1);
            end
        end

        // Mid-RUN reset clears outputs before any edge.
        we = 1'b0; re = 1'b1; ra = 5'd4; rb = 5'd4;
        step();
        check("pre-reset RA", ra32, 32'h200);
        re = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("async RA",     ra32, 32'h0);
        check("async RB",     rb32, 32'h0);
        check("async rvalid", {31'b0, rv32}, 32'h0);
        check("async ready",  {31'b0, rdy32}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Reset again at INIT index 10 while writes are attempted.
        repeat (10) step();
        check("idx10 ready", {31'b0, rdy32}, 32'h0);
        we = 1'b1; wa = 5'd3; wd = 32'hABCD1234; re = 1'b1; ra = 5'd3; rb = 5'd3;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        measure_ready("re-init", 5);

        re = 1'b1; ra = 5'd3; rb = 5'd2;
        step();
        check("post RA reg3", ra32, 32'h0);
        check("post RB reg2", rb32, 32'h0);
        ra = 5'd4; rb = 5'd5;
        step();
        check("post RA reg4", ra32, 32'h0);
        check("post RB reg5", rb32, 32'h0);
        check("post rvalid",  {31'b0, rv32}, 32'h1);
        re = 1'b0;
        step();
        check("rvalid drop", {31'b0, rv32}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; legal range 2..256.
- ADDR_W, $clog2(DEPTH), address width.
REQ-002 SHALL have the following ports (name, direction, width, meaning), one per line:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- ra, input, ADDR_W, read address, port A.
- rb, input, ADDR_W, read address, port B.
- re, input, 1, read enable; samples ra/rb this cycle.
- WriteRegister, input, ADDR_W, write address.
- RegWrite, input, 1, write enable.
- WriteData, input, DATA_W, write data.
- RA, output, DATA_W, registered read data, port A.
- RB, output, DATA_W, registered read data, port B.
- rvalid, output, 1, RA/RB hold data for the read issued the previous cycle.
- ready, output, 1, initialisation complete; accesses accepted.

Function
REQ-003 SHALL implement an FSM with states INIT and RUN; rst_n low forces INIT with clear index 0.
REQ-004 In INIT, SHALL write 0 to entry[index] each cycle, index += 1, and move to RUN on the cycle that clears index DEPTH-1 (DEPTH cycles total).
REQ-005 ready SHALL be 0 in INIT and 1 in RUN; ready rises on the cycle after the last clear.
REQ-006 In INIT, SHALL ignore RegWrite and re, and SHALL hold rvalid at 0.
REQ-007 In RUN, RegWrite=1 SHALL write WriteData to entry[WriteRegister] at the rising edge.
REQ-008 RegWrite=0 SHALL leave every entry unchanged.
REQ-009 In RUN, re=1 SHALL load RA=entry[ra] and RB=entry[rb] at the edge; rvalid=1 the next cycle (1-cycle latency).
REQ-010 re=0 SHALL hold RA/RB at their previous values and drive rvalid=0 the next cycle.
REQ-011 Addresses >= DEPTH SHALL read as 0, and writes to them SHALL be dropped.
REQ-012 ra==rb SHALL return identical data on both ports.
REQ-013 A simultaneous read and write to the same address SHALL follow REQ-019.
REQ-014 Back-to-back writes to one address SHALL leave the last value written.
REQ-015 All arithmetic SHALL be unsigned. The index counter SHALL be ADDR_W+1 bits wide so that DEPTH=2^ADDR_W terminates correctly.

Reset
REQ-016 rst_n low SHALL immediately (asynchronously) drive RA=0, RB=0, rvalid=0, ready=0, state=INIT, index=0.
REQ-017 Register contents are not guaranteed during reset; zeroing is guaranteed only by INIT.
REQ-018 Reset asserted mid-INIT or mid-RUN SHALL restart the full DEPTH-cycle clear after rst_n deasserts. Deassertion SHALL be synchronised by the integrator.

Configuration
REQ-019 Macro RF_BYPASS_EN:
- Defined: a read of address X in the same cycle as a RUN write to X SHALL return the new WriteData (write-first).
- Undefined: that read SHALL return the old contents (read-first), and the new value is visible from the next read onward.

Verification
REQ-020 DEPTH=32: release rst_n -> ready=0 for exactly 32 cycles, then 1; read all 32 addresses -> all 0, rvalid=1 one cycle after each re.
REQ-021 RUN: write 0x00000004 to reg 2 and 0x00000200 to reg 4, then re with ra=2, rb=4 -> next cycle RA=0x4, RB=0x200, rvalid=1.
REQ-022 Write reg 3=0xDEADBEEF while re with ra=3 in the same cycle:
- With RF_BYPASS_EN -> RA=0xDEADBEEF.
- Without it -> RA=0x0, then RA=0xDEADBEEF on the following read.
REQ-023 Assert rst_n low for 1 cycle at INIT index 10 with RegWrite=1 -> ready stays 0 for a fresh 32 cycles, and the write is dropped (reg reads 0).
REQ-024 DEPTH=20: write 0x55 to address 25, then read ra=25, rb=19 -> RA=0, RB=0; ready rose after exactly 20 cycles.
REQ-025 Assert rst_n low mid-RUN with RA=0x200 -> RA=0, rvalid=0 in the same cycle without waiting for a clock edge.
